output_dispatcher: RTL and testbench

Parametrised multi-channel successor to the single-FIFO output controller. Drains up to CHANNELS synchronous FIFOs in round-robin order, presents one word at a time on a shared output bus tagged with its channel number, and signals each word to the host with an IRQ. The IRQ is either a fixed-length pulse or held until host acknowledge, with a timeout. Sits between the acquisition FIFOs and the host/MCU interface, entirely in the `clock` domain; no generated FIFO read clock.

---
 rtl/output_dispatcher_pkg.sv | 25 ++
 rtl/output_dispatcher_rr_arbiter.sv | 36 +++
 rtl/output_dispatcher.sv | 153 +++++++++++++++
 tb/tb_output_dispatcher.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_dispatcher_pkg.sv
// Shared types and sizing helpers for the multi-channel output dispatcher.
package output_dispatcher_pkg;

    localparam int unsigned TIMEOUT_CNT_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        READ    = ST_READ,
        CAPTURE = ST_CAPTURE,
        HOLD    = ST_HOLD,
        GAP     = ST_GAP
    } state_e;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/output_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first requester above ptr, with wrap-around.
module rr_arbiter
    import output_dispatcher_pkg::*;
#(
    parameter int unsigned N = 4
)(
    input  logic [N-1:0]             req,
    input  logic [ch_width(N)-1:0]   ptr,
    output logic [N-1:0]             grant,
    output logic [ch_width(N)-1:0]   grant_idx,
    output logic                     grant_valid
);

    localparam int unsigned IW = ch_width(N);

    // Search ptr+1, ptr+2, ... ptr+N (mod N); the first hit wins.
    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!grant_valid && req[IW'(cand)]) begin
                grant_valid       = 1'b1;
                grant_idx         = IW'(cand);
                grant[IW'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_dispatcher.sv
// Round-robin drain of several FIFOs onto one tagged output bus with an IRQ per word.
module output_dispatcher
    import output_dispatcher_pkg::*;
#(
    parameter int unsigned DATA_W   = 11,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned LEVEL_W  = 4,
    parameter int unsigned IRQ_HOLD = 36,
    parameter int unsigned ACK_MODE = 0
)(
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_W-1:0]     fifo_data_in,
    input  logic [CHANNELS*LEVEL_W-1:0]    fifo_level,
    output logic [CHANNELS-1:0]            fifo_read_request,
    output logic [DATA_W-1:0]              data_out,
    output logic [ch_width(CHANNELS)-1:0]  channel_out,
    output logic                           IRQ,
    input  logic                           irq_ack,
    output logic [TIMEOUT_CNT_W-1:0]       timeout_count,
    output logic                           busy
);

    localparam int unsigned CH_W = ch_width(CHANNELS);
    localparam int unsigned HC_W = $clog2(IRQ_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(IRQ_HOLD - 1);
    localparam logic [TIMEOUT_CNT_W-1:0] TO_MAX = '1;
    localparam logic ACK_EN = (ACK_MODE != 0);

    state_e                     state_q, state_d;
    logic [CH_W-1:0]            ptr_q, ptr_d;
    logic [CH_W-1:0]            gidx_q, gidx_d;
    logic [HC_W-1:0]            hold_cnt_q, hold_cnt_d;
    logic [CHANNELS-1:0]        rd_d;
    logic [DATA_W-1:0]          data_d;
    logic [CH_W-1:0]            chan_d;
    logic                       irq_d;
    logic [TIMEOUT_CNT_W-1:0]   to_d;
    logic                       busy_d;

    logic [CHANNELS-1:0]        req;
    logic [CHANNELS-1:0]        arb_grant;
    logic [CH_W-1:0]            arb_idx;
    logic                       arb_valid;

    // A channel requests service whenever its fill level is nonzero.
    always_comb begin
        req = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            req[k] = |fifo_level[k*LEVEL_W +: LEVEL_W];
        end
    end

    rr_arbiter #(
        .N (CHANNELS)
    ) u_arb (
        .req         (req),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IDLE;
            ptr_q             <= CH_W'(CHANNELS - 1);
            gidx_q            <= '0;
            hold_cnt_q        <= '0;
            fifo_read_request <= '0;
            data_out          <= '0;
            channel_out       <= '0;
            IRQ               <= 1'b0;
            timeout_count     <= '0;
            busy              <= 1'b0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            gidx_q            <= gidx_d;
            hold_cnt_q        <= hold_cnt_d;
            fifo_read_request <= rd_d;
            data_out          <= data_d;
            channel_out       <= chan_d;
            IRQ               <= irq_d;
            timeout_count     <= to_d;
            busy              <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        hold_cnt_d = hold_cnt_q;
        rd_d       = '0;
        data_d     = data_out;
        chan_d     = channel_out;
        irq_d      = IRQ;
        to_d       = timeout_count;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = READ;
                    rd_d    = arb_grant;
                    ptr_d   = arb_idx;
                    gidx_d  = arb_idx;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    if (gidx_q == CH_W'(k)) begin
                        data_d = fifo_data_in[k*DATA_W +: DATA_W];
                    end
                end
                chan_d     = gidx_q;
                irq_d      = 1'b1;
                hold_cnt_d = '0;
                state_d    = HOLD;
            end
            HOLD: begin
                // Ack beats a coinciding timeout.
                if (ACK_EN && irq_ack) begin
                    irq_d   = 1'b0;
                    state_d = GAP;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    irq_d   = 1'b0;
                    state_d = GAP;
                    if (ACK_EN && (timeout_count != TO_MAX)) begin
                        to_d = timeout_count + 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_output_dispatcher.sv
// Scoreboard bench: two dispatchers (pulse mode and ack mode) fed by modelled FIFOs.
`timescale 1ns/1ps
module tb_output_dispatcher;

    localparam int unsigned DW     = 11;
    localparam int unsigned NCH    = 4;
    localparam int unsigned LW     = 4;
    localparam int unsigned HOLD_P = 36;
    localparam int unsigned HOLD_A = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NCH*DW-1:0] fdata_p = '0, fdata_a = '0;
    logic [NCH*LW-1:0] lvl_p = '0, lvl_a = '0;
    logic [NCH-1:0]    rd_p, rd_a;
    logic [DW-1:0]     dout_p, dout_a;
    logic [1:0]        ch_p, ch_a;
    logic              irq_p, irq_a;
    logic              ack_p = 1'b0, ack_a = 1'b0;
    logic [15:0]       to_p, to_a;
    logic              busy_p, busy_a;

    output_dispatcher #(.DATA_W(DW), .CHANNELS(NCH), .LEVEL_W(LW), .IRQ_HOLD(HOLD_P), .ACK_MODE(0)) dut_p (
        .clock(clock), .reset(reset), .fifo_data_in(fdata_p), .fifo_level(lvl_p),
        .fifo_read_request(rd_p), .data_out(dout_p), .channel_out(ch_p), .IRQ(irq_p),
        .irq_ack(ack_p), .timeout_count(to_p), .busy(busy_p));

    output_dispatcher #(.DATA_W(DW), .CHANNELS(NCH), .LEVEL_W(LW), .IRQ_HOLD(HOLD_A), .ACK_MODE(1)) dut_a (
        .clock(clock), .reset(reset), .fifo_data_in(fdata_a), .fifo_level(lvl_a),
        .fifo_read_request(rd_a), .data_out(dout_a), .channel_out(ch_a), .IRQ(irq_a),
        .irq_ack(ack_a), .timeout_count(to_a), .busy(busy_a));

    int n_cmp = 0;
    int n_fail = 0;

    logic [DW-1:0]   fq    [2][NCH][$];
    logic [DW-1:0]   exp_q [2][NCH][$];
    logic [DW+1:0]   sb    [2][$];
    logic            push_en [2];
    int              push_ch [2];
    logic [DW-1:0]   push_dat[2];
    logic            rst_q = 1'b1;
    logic [NCH-1:0]  prev_ne [2];

    int              model_ptr[2], since_rd[2], high_cnt[2], gap_st[2], ack_plan[2];
    logic [NCH-1:0]  rd_prev[2];
    logic            irq_prev[2];
    logic [15:0]     exp_to[2];
    logic            in_hold = 1'b0;
    int              hcyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] nonempty(input logic [NCH*LW-1:0] l);
        logic [NCH-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) r[k] = (l[k*LW +: LW] != '0);
        return r;
    endfunction

    task automatic model_reset(input int d);
        model_ptr[d] = NCH - 1;
        sb[d].delete();
        since_rd[d]  = -1;
        high_cnt[d]  = 0;
        gap_st[d]    = 0;
        rd_prev[d]   = '0;
        irq_prev[d]  = 1'b0;
        exp_to[d]    = '0;
    endtask

    // FIFO model: pop on strobe (data valid next cycle), accept pushes, publish levels.
    task automatic fifo_step(input int d, input logic [NCH-1:0] rd);
        for (int k = 0; k < NCH; k++) begin
            if (rd[k] && fq[d][k].size() > 0) begin
                logic [DW-1:0] w;
                w = fq[d][k].pop_front();
                if (d == 0) fdata_p[k*DW +: DW] <= w;
                else        fdata_a[k*DW +: DW] <= w;
            end
        end
        if (push_en[d]) fq[d][push_ch[d]].push_back(push_dat[d]);
        for (int k = 0; k < NCH; k++) begin
            if (d == 0) lvl_p[k*LW +: LW] <= LW'(fq[d][k].size());
            else        lvl_a[k*LW +: LW] <= LW'(fq[d][k].size());
        end
    endtask

    always @(posedge clock) begin
        rst_q      <= reset;
        prev_ne[0] <= nonempty(lvl_p);
        prev_ne[1] <= nonempty(lvl_a);
        fifo_step(0, rd_p);
        fifo_step(1, rd_a);
    end

    // Monitor: predicts grants from the levels seen at the decision edge, checks words and IRQ timing.
    task automatic mon(input int d, input logic [NCH-1:0] rd, input logic irq, input logic [DW-1:0] dout,
                       input logic [1:0] ch, input logic bsy, input logic [15:0] tcnt);
        string p;
        int exp_hi;
        p = (d == 0) ? "p" : "a";
        if (rst_q) begin
            model_reset(d);
            return;
        end
        if (since_rd[d] >= 0) since_rd[d]++;
        if (gap_st[d] == 1) begin
            chk($sformatf("%s_idle_busy", p), 32'(bsy), 32'd0);
            gap_st[d] = 0;
        end
        if (rd != '0 && rd_prev[d] == '0) begin
            logic [NCH-1:0] ne;
            int g;
            g  = -1;
            ne = prev_ne[d];
            for (int i = 1; i <= NCH; i++) begin
                int c;
                c = (model_ptr[d] + i) % NCH;
                if (g < 0 && ne[c]) g = c;
            end
            chk($sformatf("%s_grant", p), 32'(rd), (g < 0) ? 32'd0 : (32'd1 << g));
            chk($sformatf("%s_read_busy", p), 32'(bsy), 32'd1);
            if (g >= 0) begin
                model_ptr[d] = g;
                if (exp_q[d][g].size() > 0) sb[d].push_back({2'(g), exp_q[d][g].pop_front()});
                since_rd[d] = 0;
            end
        end else if (rd_prev[d] != '0) begin
            chk($sformatf("%s_strobe_len", p), 32'(rd), 32'd0);
        end
        if (irq && !irq_prev[d]) begin
            chk($sformatf("%s_irq_latency", p), 32'(since_rd[d]), 32'd2);
            since_rd[d] = -1;
            if (sb[d].size() == 0) begin
                chk($sformatf("%s_unexpected_word", p), 32'd1, 32'd0);
            end else begin
                logic [DW+1:0] e;
                e = sb[d].pop_front();
                chk($sformatf("%s_data", p), 32'(dout), 32'(e[DW-1:0]));
                chk($sformatf("%s_channel", p), 32'(ch), 32'(e[DW+1:DW]));
            end
            high_cnt[d] = 1;
        end else if (irq) begin
            high_cnt[d]++;
        end else if (irq_prev[d]) begin
            if (d == 0) begin
                exp_hi = HOLD_P;
            end else begin
                exp_hi = (ack_plan[1] <= HOLD_A) ? ack_plan[1] : HOLD_A;
                if (ack_plan[1] > HOLD_A && exp_to[1] != 16'hFFFF) exp_to[1]++;
            end
            chk($sformatf("%s_irq_high", p), 32'(high_cnt[d]), 32'(exp_hi));
            chk($sformatf("%s_timeouts", p), 32'(tcnt), 32'(exp_to[d]));
            chk($sformatf("%s_gap_busy", p), 32'(bsy), 32'd1);
            gap_st[d] = 1;
        end
        rd_prev[d]  = rd;
        irq_prev[d] = irq;
    endtask

    always @(negedge clock) begin
        mon(0, rd_p, irq_p, dout_p, ch_p, busy_p, to_p);
        mon(1, rd_a, irq_a, dout_a, ch_a, busy_a, to_a);
    end

    // One cycle of stimulus; ack for dut_a follows a per-word plan (ack at HOLD cycle n, n>10 means none).
    task automatic step();
        @(posedge clock);
        #1;
        push_en[0] = 1'b0;
        push_en[1] = 1'b0;
        ack_p = ($urandom_range(0, 3) == 0);
        if (irq_a) begin
            if (!in_hold) begin
                in_hold     = 1'b1;
                hcyc        = 1;
                ack_plan[1] = $urandom_range(1, 14);
            end else begin
                hcyc++;
            end
            ack_a = (hcyc == ack_plan[1]);
        end else begin
            in_hold = 1'b0;
            ack_a   = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push(input int d, input int ch, input logic [DW-1:0] v);
        push_en[d]  = 1'b1;
        push_ch[d]  = ch;
        push_dat[d] = v;
        exp_q[d][ch].push_back(v);
    endtask

    task automatic chk_reset();
        chk("p_rst_rd",   32'(rd_p),   32'd0);
        chk("p_rst_data", 32'(dout_p), 32'd0);
        chk("p_rst_chan", 32'(ch_p),   32'd0);
        chk("p_rst_irq",  32'(irq_p),  32'd0);
        chk("p_rst_to",   32'(to_p),   32'd0);
        chk("p_rst_busy", 32'(busy_p), 32'd0);
        chk("a_rst_rd",   32'(rd_a),   32'd0);
        chk("a_rst_data", 32'(dout_a), 32'd0);
        chk("a_rst_chan", 32'(ch_a),   32'd0);
        chk("a_rst_irq",  32'(irq_a),  32'd0);
        chk("a_rst_to",   32'(to_a),   32'd0);
        chk("a_rst_busy", 32'(busy_a), 32'd0);
    endtask

    task automatic wait_first_grant(input string name);
        int t;
        t = 0;
        while (rd_p == '0 && t < 400) begin
            step();
            t++;
        end
        chk(name, 32'(rd_p), 32'd1);
    endtask

    function automatic int remaining();
        int r;
        r = 0;
        for (int d = 0; d < 2; d++) begin
            r += sb[d].size();
            for (int k = 0; k < NCH; k++) r += exp_q[d][k].size();
        end
        return r;
    endfunction

    initial begin
        int t;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            push_en[d]  = 1'b0;
            push_ch[d]  = 0;
            push_dat[d] = '0;
            prev_ne[d]  = '0;
            ack_plan[d] = 0;
        end
        reset = 1'b1;
        run(3);
        chk_reset();
        reset = 1'b0;

        // Single word on channel 0.
        push(0, 0, 11'h5A5);
        push(1, 0, 11'h5A5);
        step();
        run(60);

        // Every channel holds two distinct words.
        for (int w = 0; w < 2; w++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                push(0, ch, DW'(11'h300 + 16 * ch + w));
                push(1, ch, DW'(11'h300 + 16 * ch + w));
                step();
            end
        end
        run(8 * 42);

        // Channels 1 and 3 empty.
        for (int w = 0; w < 3; w++) begin
            for (int ch = 0; ch < NCH; ch += 2) begin
                push(0, ch, DW'(11'h600 + 16 * ch + w));
                push(1, ch, DW'(11'h600 + 16 * ch + w));
                step();
            end
        end
        run(6 * 42 + 50);

        // Random traffic.
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int d = 0; d < 2; d++) begin
                    int ch;
                    ch = $urandom_range(0, NCH - 1);
                    if (fq[d][ch].size() < 12) push(d, ch, DW'($urandom));
                end
            end
            step();
        end

        // Reset while dut_p holds its IRQ.
        for (int ch = 0; ch < NCH; ch++) begin
            push(0, ch, DW'($urandom));
            push(1, ch, DW'($urandom));
            step();
        end
        t = 0;
        while (!irq_p && t < 2000) begin
            step();
            t++;
        end
        chk("wait_hold", 32'(irq_p), 32'd1);
        run(3);
        reset = 1'b1;
        step();
        chk_reset();
        push(0, 0, DW'($urandom));
        push(1, 0, DW'($urandom));
        step();
        reset = 1'b0;
        wait_first_grant("p_first_grant_after_hold_reset");

        // Reset while dut_p strobes a read (that word is lost).
        reset = 1'b1;
        step();
        chk_reset();
        push(0, 0, DW'($urandom));
        push(1, 0, DW'($urandom));
        step();
        reset = 1'b0;
        wait_first_grant("p_first_grant_after_read_reset");

        // Drain everything still queued.
        t = 0;
        while (t < 8000 && !(remaining() == 0 && !busy_p && !busy_a)) begin
            step();
            t++;
        end
        run(5);
        chk("leftover_words", 32'(remaining()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
